// File: rtl/arb4_rr_hold.sv
// Four-requester round-robin arbiter with a bounded grant hold time.
// A grant ends on done, on the owner dropping its request, or by forced revoke after MAX_HOLD cycles.
//   state | meaning
//   IDLE  | no grant; arbitrate req from ptr, or dead cycle after a grant ends
//   GRANT | one requester owns the resource; hold_cnt counts cycles held
module arb4_rr_hold #(
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input  logic       CK,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] hold_cnt;

  logic [1:0] pick_idx;
  logic [1:0] cand;
  logic       release_now;

  // Scan from the farthest candidate back to ptr so the nearest set bit wins.
  always_comb begin
    pick_idx = ptr;
    cand     = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) pick_idx = cand;
    end
  end

  assign release_now = done | ~req[owner];

  always_ff @(posedge CK) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      owner    <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      ptr      <= 2'd0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (req != 4'b0000) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << pick_idx;
            owner    <= pick_idx;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            gnt  <= 4'b0000;
            busy <= 1'b0;
          end
        end
        GRANT: begin
          if (release_now || hold_cnt == HOLD_LAST) begin
            // A release in the final hold cycle takes priority over the revoke.
            state   <= IDLE;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            timeout <= ~release_now;
            ptr     <= owner + 2'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb4_rr_hold.sv
// Directed bench for arb4_rr_hold: reset, rotation, timeout, release priority and mid-grant reset.
module tb_arb4_rr_hold;

  logic       CK = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  arb4_rr_hold #(.MAX_HOLD(15), .CW(4)) dut (
    .CK(CK), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset gnt=%b busy=%b owner=%0d timeout=%b required 0000 0 0 0", gnt, busy, owner, timeout);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req gnt=%b busy=%b required 0000 0", gnt, busy);
    end
  endtask

  task automatic test_basic();
    req = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_first gnt=%b owner=%0d busy=%b required 0010 1 1", gnt, owner, busy);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_dead gnt=%b busy=%b timeout=%b required 0000 0 0", gnt, busy, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_second gnt=%b owner=%0d busy=%b required 1000 3 1", gnt, owner, busy);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_rotation();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001};
    req = 4'b1111; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (gnt !== exp_seq[i]) begin
        errors++;
        $display("FAIL rotation[%0d] gnt=%b required %b", i, gnt, exp_seq[i]);
      end
    end
    req = 4'b0000; done = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    req = 4'b0001;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (gnt !== 4'b0001 || timeout !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_hold bad_cycles=%0d required 0", bad);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse gnt=%b timeout=%b busy=%b required 0000 1 0", gnt, timeout, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_regrant gnt=%b timeout=%b required 0001 0", gnt, timeout);
    end
  endtask

  task automatic test_done_at_last();
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL last_cycle_hold gnt=%b required 0001", gnt);
    end
    done = 1'b1;
    tick();
    done = 1'b0; req = 4'b0000;
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL done_wins gnt=%b timeout=%b required 0000 0", gnt, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b0 || gnt !== 4'b0000) begin
      errors++;
      $display("FAIL done_wins_after gnt=%b timeout=%b required 0000 0", gnt, timeout);
    end
  endtask

  task automatic test_reset_mid_grant();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL rst_mid_grant_start gnt=%b owner=%0d required 0100 2", gnt, owner);
    end
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0 || owner !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_grant gnt=%b busy=%b timeout=%b owner=%0d required 0000 0 0 0",
               gnt, busy, timeout, owner);
    end
    rst = 1'b0; req = 4'b1100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL rst_ptr_zero gnt=%b owner=%0d required 0100 2", gnt, owner);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_owner_drop();
    req = 4'b0110;
    tick();
    checks++;
    if (gnt !== 4'b0010 || owner !== 2'd1) begin
      errors++;
      $display("FAIL drop_grant gnt=%b owner=%0d required 0010 1", gnt, owner);
    end
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL nonowner_ignored gnt=%b required 0010", gnt);
    end
    req = 4'b1100;
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_release gnt=%b timeout=%b busy=%b required 0000 0 0", gnt, timeout, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      errors++;
      $display("FAIL drop_ptr_advance gnt=%b owner=%0d required 0100 2", gnt, owner);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_timeout();
    test_done_at_last();
    test_reset_mid_grant();
    test_owner_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
